// File: rtl/aes_kat_selftest.sv
// Known-answer self-test sequencer for an AES encrypt/decrypt engine.
// Walks NVEC vectors from an external ROM. Each vector is encrypted and then decrypted
// through a start/done engine handshake, with a watchdog on every wait.
module aes_kat_selftest #(
  parameter int unsigned Nk      = 4,
  parameter int unsigned Nr      = Nk + 6,
  parameter int unsigned NVEC    = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned VW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [VW-1:0]    vec_idx,
  input  logic [127:0]     vec_pt,
  input  logic [Nk*32-1:0] vec_key,
  input  logic [127:0]     vec_ct,
  output logic             eng_start,
  output logic             eng_mode,
  output logic [127:0]     eng_data,
  output logic [Nk*32-1:0] eng_key,
  input  logic             eng_done,
  input  logic [127:0]     eng_result,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout_err,
  output logic [VW-1:0]    fail_idx,
  output logic             fail_dir
);

  localparam int unsigned     WdW     = $clog2(TIMEOUT);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [VW-1:0]   IdxLast = VW'(NVEC - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StEncReq, StEncWait, StDecReq, StDecWait, StDone
  } state_e;

  state_e             state_q;
  logic [VW-1:0]      vec_idx_q;
  logic [127:0]       pt_q;
  logic [Nk*32-1:0]   key_q;
  logic [127:0]       ct_q;
  logic [WdW-1:0]     wd_q;
  logic               eng_mode_q;
  logic [127:0]       eng_data_q;
  logic               pass_q;
  logic               fail_q;
  logic               timeout_err_q;
  logic [VW-1:0]      fail_idx_q;
  logic               fail_dir_q;

  // Nr is informational only.
  logic unused_nr;
  assign unused_nr = ^Nr;

  // Sequencer: walks vectors, drives the engine, checks results and runs the watchdog.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      vec_idx_q     <= '0;
      pt_q          <= '0;
      key_q         <= '0;
      ct_q          <= '0;
      wd_q          <= '0;
      eng_mode_q    <= 1'b0;
      eng_data_q    <= '0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      fail_idx_q    <= '0;
      fail_dir_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            vec_idx_q     <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            fail_idx_q    <= '0;
            fail_dir_q    <= 1'b0;
            state_q       <= StLoad;
          end
        end
        StLoad: begin
          pt_q       <= vec_pt;
          key_q      <= vec_key;
          ct_q       <= vec_ct;
          // Engine inputs are set up here so they are valid during the request cycle.
          eng_mode_q <= 1'b0;
          eng_data_q <= vec_pt;
          state_q    <= StEncReq;
        end
        StEncReq: begin
          wd_q    <= '0;
          state_q <= StEncWait;
        end
        StEncWait: begin
          // A done arriving on the last watchdog cycle still counts as an answer.
          if (eng_done) begin
            if (eng_result == ct_q) begin
              eng_mode_q <= 1'b1;
              eng_data_q <= ct_q;
              state_q    <= StDecReq;
            end else begin
              fail_q     <= 1'b1;
              fail_dir_q <= 1'b0;
              fail_idx_q <= vec_idx_q;
              state_q    <= StDone;
            end
          end else if (wd_q == WdLast) begin
            fail_q        <= 1'b1;
            timeout_err_q <= 1'b1;
            fail_dir_q    <= 1'b0;
            fail_idx_q    <= vec_idx_q;
            state_q       <= StDone;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StDecReq: begin
          wd_q    <= '0;
          state_q <= StDecWait;
        end
        StDecWait: begin
          if (eng_done) begin
            if (eng_result == pt_q) begin
              if (vec_idx_q == IdxLast) begin
                pass_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                vec_idx_q <= vec_idx_q + VW'(1);
                state_q   <= StLoad;
              end
            end else begin
              fail_q     <= 1'b1;
              fail_dir_q <= 1'b1;
              fail_idx_q <= vec_idx_q;
              state_q    <= StDone;
            end
          end else if (wd_q == WdLast) begin
            fail_q        <= 1'b1;
            timeout_err_q <= 1'b1;
            fail_dir_q    <= 1'b1;
            fail_idx_q    <= vec_idx_q;
            state_q       <= StDone;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec_idx     = vec_idx_q;
  assign eng_start   = (state_q == StEncReq) || (state_q == StDecReq);
  assign eng_mode    = eng_mode_q;
  assign eng_data    = eng_data_q;
  assign eng_key     = key_q;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout_err = timeout_err_q;
  assign fail_idx    = fail_idx_q;
  assign fail_dir    = fail_dir_q;

endmodule

// File: tb/tb_aes_kat_selftest.sv
// Self-checking bench for aes_kat_selftest: table-lookup engine, random vector ROM,
// and an outcome/timing model computed per vector and direction.
module tb_aes_kat_selftest;

  localparam int unsigned NK      = 4;
  localparam int unsigned KW      = NK * 32;
  localparam int unsigned NVEC    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned VW      = 8;
  localparam int unsigned IW      = 2;

  logic           clk;
  logic           reset;
  logic           start;
  logic [VW-1:0]  vec_idx;
  logic [127:0]   vec_pt;
  logic [KW-1:0]  vec_key;
  logic [127:0]   vec_ct;
  logic           eng_start;
  logic           eng_mode;
  logic [127:0]   eng_data;
  logic [KW-1:0]  eng_key;
  logic           eng_done;
  logic [127:0]   eng_result;
  logic           busy;
  logic           pass;
  logic           fail;
  logic           timeout_err;
  logic [VW-1:0]  fail_idx;
  logic           fail_dir;

  logic [127:0]   rom_pt  [NVEC];
  logic [KW-1:0]  rom_key [NVEC];
  logic [127:0]   rom_ct  [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  // Engine behaviour for the current run.
  int cfg_lat    = 3;
  int cfg_silent = -1;
  int cfg_cvec   = -1;
  int cfg_cdir   = -1;
  int starts_run = 0;
  logic prev_start = 1'b0;

  aes_kat_selftest #(
    .Nk(NK), .Nr(NK + 6), .NVEC(NVEC), .TIMEOUT(TIMEOUT), .VW(VW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vec_idx(vec_idx),
    .vec_pt(vec_pt), .vec_key(vec_key), .vec_ct(vec_ct),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_data(eng_data), .eng_key(eng_key),
    .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy), .pass(pass), .fail(fail), .timeout_err(timeout_err),
    .fail_idx(fail_idx), .fail_dir(fail_dir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got no end of test, expected completion");
    $fatal(1, "time limit");
  end

  // Combinational vector ROM; out-of-range addresses read as zero.
  always_comb begin
    vec_pt  = '0;
    vec_key = '0;
    vec_ct  = '0;
    if (int'(vec_idx) < NVEC) begin
      vec_pt  = rom_pt[vec_idx[IW-1:0]];
      vec_key = rom_key[vec_idx[IW-1:0]];
      vec_ct  = rom_ct[vec_idx[IW-1:0]];
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Ideal cipher stand-in: encrypt maps a table pt to its ct under the table key, and back.
  function automatic logic [127:0] oracle(input logic mode, input logic [127:0] data,
                                          input logic [KW-1:0] key, output int hit);
    logic [127:0] r;
    r   = ~data;
    hit = -1;
    for (int i = 0; i < NVEC; i++) begin
      if (hit < 0 && rom_key[i] == key) begin
        if (!mode && data == rom_pt[i]) begin
          r = rom_ct[i];
          hit = i;
        end else if (mode && data == rom_ct[i]) begin
          r = rom_pt[i];
          hit = i;
        end
      end
    end
    return r;
  endfunction

  task automatic rand_rom();
    for (int i = 0; i < NVEC; i++) begin
      rom_pt[i] = {$urandom, $urandom, $urandom, $urandom};
      rom_ct[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < int'(NK); w++) rom_key[i][w*32 +: 32] = $urandom;
    end
    rom_pt[0]  = 128'h00112233445566778899aabbccddeeff;
    rom_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
    rom_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  endtask

  // Engine + handshake monitor, acting 1 time unit after each rising edge.
  initial begin
    logic [127:0] resp;
    logic [127:0] hold_data;
    logic [KW-1:0] hold_key;
    int cnt;
    int hit;
    int req_no;
    int vi;
    eng_done = 1'b0;
    eng_result = '0;
    resp = '0;
    hold_data = '0;
    hold_key = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (pass || fail) check("pass_fail_exclusive", 256'(pass && fail), 256'(0));
      if (!reset) begin
        cnt = 0;
        prev_start = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng_done = 1'b1;
            eng_result = resp;
            check("eng_key_hold", 256'(eng_key), 256'(hold_key));
            check("eng_data_hold", 256'(eng_data), 256'(hold_data));
          end
        end
        if (eng_start) begin
          req_no = starts_run;
          starts_run++;
          vi = req_no / 2;
          check("start_gap", 256'(prev_start), 256'(0));
          check("eng_mode_order", 256'(eng_mode), 256'(req_no % 2));
          if (vi < NVEC) begin
            hold_key  = rom_key[vi];
            hold_data = (req_no % 2 == 1) ? rom_ct[vi] : rom_pt[vi];
            check("eng_key", 256'(eng_key), 256'(hold_key));
            check("eng_data", 256'(eng_data), 256'(hold_data));
          end
          if (req_no != cfg_silent) begin
            cnt = cfg_lat;
            resp = oracle(eng_mode, eng_data, eng_key, hit);
            if (hit == cfg_cvec && int'(eng_mode) == cfg_cdir) resp[0] = ~resp[0];
          end
        end
        prev_start = eng_start;
      end
    end
  end

  // Outcome model: each vector costs a load cycle plus, per direction, a request cycle and
  // the wait (engine latency, or TIMEOUT if the engine stays silent or is too slow).
  task automatic model(input int lat, input int silent, input int cvec, input int cdir,
                       output bit p, output bit f, output bit t, output int idx,
                       output int dir, output int cyc, output int starts);
    bit stop;
    p = 0; f = 0; t = 0; idx = 0; dir = 0; cyc = 0; starts = 0; stop = 0;
    for (int i = 0; i < NVEC && !stop; i++) begin
      cyc++;
      for (int d = 0; d < 2 && !stop; d++) begin
        cyc++;
        starts++;
        if (starts - 1 == silent || lat > int'(TIMEOUT)) begin
          cyc += TIMEOUT;
          f = 1; t = 1; idx = i; dir = d; stop = 1;
        end else begin
          cyc += lat;
          if (i == cvec && d == cdir) begin
            f = 1; idx = i; dir = d; stop = 1;
          end
        end
      end
    end
    p = !f;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vec_idx"}, 256'(vec_idx), 256'(0));
    check({tag, "_eng_start"}, 256'(eng_start), 256'(0));
    check({tag, "_eng_mode"}, 256'(eng_mode), 256'(0));
    check({tag, "_eng_data"}, 256'(eng_data), 256'(0));
    check({tag, "_eng_key"}, 256'(eng_key), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_pass"}, 256'(pass), 256'(0));
    check({tag, "_fail"}, 256'(fail), 256'(0));
    check({tag, "_timeout_err"}, 256'(timeout_err), 256'(0));
    check({tag, "_fail_idx"}, 256'(fail_idx), 256'(0));
    check({tag, "_fail_dir"}, 256'(fail_dir), 256'(0));
  endtask

  task automatic run(input string tag, input int lat, input int silent, input int cvec,
                     input int cdir, input bit kick);
    bit e_pass, e_fail, e_to;
    int e_idx, e_dir, e_cyc, e_starts;
    int cyc;
    int kick_at;
    model(lat, silent, cvec, cdir, e_pass, e_fail, e_to, e_idx, e_dir, e_cyc, e_starts);
    cfg_lat = lat;
    cfg_silent = silent;
    cfg_cvec = cvec;
    cfg_cdir = cdir;
    starts_run = 0;
    kick_at = kick ? e_cyc / 2 : -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    check({tag, "_busy_after_start"}, 256'(busy), 256'(1));
    while (!(pass || fail) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == kick_at);
    end
    start = 1'b0;
    check({tag, "_cycles"}, 256'(cyc), 256'(e_cyc));
    check({tag, "_pass"}, 256'(pass), 256'(e_pass));
    check({tag, "_fail"}, 256'(fail), 256'(e_fail));
    check({tag, "_timeout_err"}, 256'(timeout_err), 256'(e_to));
    check({tag, "_fail_idx"}, 256'(fail_idx), 256'(e_idx));
    check({tag, "_fail_dir"}, 256'(fail_dir), 256'(e_dir));
    check({tag, "_starts"}, 256'(starts_run), 256'(e_starts));
    check({tag, "_busy_end"}, 256'(busy), 256'(0));
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid_dec();
    int n;
    cfg_lat = 5;
    cfg_silent = -1;
    cfg_cvec = -1;
    cfg_cdir = -1;
    starts_run = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(starts_run == 2 && !eng_start) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_reached_dec_wait", 256'(n < 200 && busy && eng_mode), 256'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("rst_mid");
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int lat;
    int sel;
    reset = 1'b0;
    start = 1'b0;
    rand_rom();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run("fips_l3", 3, -1, -1, -1, 1'b0);
    run("busy_kick", 4, -1, -1, -1, 1'b1);
    run("dec2_bit0", 3, -1, 2, 1, 1'b0);
    run("rerun_pass", 2, -1, -1, -1, 1'b0);
    run("enc1_bad", 1, -1, 1, 0, 1'b0);
    run("to_enc0", 3, 0, -1, -1, 1'b0);
    run("l64_edge", 64, -1, -1, -1, 1'b0);
    run("l65_timeout", 65, -1, -1, -1, 1'b0);
    run("to_dec2", 2, 5, -1, -1, 1'b0);
    reset_mid_dec();
    run("after_reset", 1, -1, -1, -1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rand_rom();
      lat = int'($urandom_range(1, 12));
      sel = int'($urandom_range(0, 2));
      if (sel == 0)
        run("rand_pass", lat, -1, -1, -1, 1'($urandom_range(0, 1)));
      else if (sel == 1)
        run("rand_corrupt", lat, -1, int'($urandom_range(0, NVEC - 1)),
            int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        run("rand_silent", lat, int'($urandom_range(0, 2 * NVEC - 1)), -1, -1,
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
